// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the tracker entry layout and the youngest-producer search.
package pipe_hazard_pkg;

    // Widest register address and deepest pipeline the shared types can carry.
    localparam int MAX_REG_AW = 8;
    localparam int MAX_STAGES = 6;
    localparam int IDX_W      = 3;

    // Forwarding select value meaning "use the register bank read".
    localparam int FWD_REG = 0;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] dst;
        logic                  regw;
        logic                  load;
    } trk_entry_t;

    // Result of a producer search: stage number is 1-based (1 = E).
    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic             load;
    } match_t;

    // Find the youngest in-flight producer of src. Unused slots must be
    // zero, so they never match. Scanning oldest to youngest lets the
    // youngest hit overwrite any older one.
    function automatic match_t youngest_match(
        input trk_entry_t [MAX_STAGES-1:0] trk,
        input logic [MAX_REG_AW-1:0]       src,
        input logic                        used
    );
        match_t m;
        m = '0;
        for (int j = MAX_STAGES - 1; j >= 0; j--) begin
            if (used && trk[j].valid && trk[j].regw && (trk[j].dst == src)) begin
                m.hit  = 1'b1;
                m.idx  = IDX_W'(j + 1);
                m.load = trk[j].load;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_track_entry.sv
// One tracker slot: holds an in-flight instruction's destination info
// for a single pipeline stage, with freeze and bubble-insert control.
module pipe_track_entry
    import pipe_hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold_i,
    input  logic       bubble_i,
    input  trk_entry_t d_i,
    output trk_entry_t q_o
);

    trk_entry_t entry_q;
    trk_entry_t entry_d;

    // Next slot contents: keep while frozen, otherwise take upstream or a bubble.
    always_comb begin
        entry_d = entry_q;
        if (!hold_i) begin
            entry_d = bubble_i ? '0 : d_i;
        end
    end

    // Slot register with synchronous reset to an empty (invalid) entry.
    // NOTE: clocked state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks destinations of in-flight instructions
// from E to W and produces stall, flush, hold, issue and registered operand
// forwarding selects for the E stage.
// Optional feature macro: PIPE_HAZARD_FORWARD_EN (enables forwarding; when
// undefined, every unresolved dependency stalls until the producer is in W).
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int STAGES = 3,
    parameter int FW     = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src_a,
    input  logic [REG_AW-1:0] id_src_b,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regw,
    input  logic              id_load,
    input  logic              ex_branch_taken,
    input  logic              mem_wait,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              pipe_hold,
    output logic              issue,
    output logic [FW-1:0]     fwd_a_e,
    output logic [FW-1:0]     fwd_b_e
);

    trk_entry_t                    id_entry;
    trk_entry_t [STAGES:1]         trk_q;
    trk_entry_t [MAX_STAGES-1:0]   trk_all;
    match_t                        match_a;
    match_t                        match_b;
    logic                          stall_a;
    logic                          stall_b;
    logic                          hazard_stall;

    assign id_entry = '{valid: 1'b1, dst: MAX_REG_AW'(id_dst), regw: id_regw, load: id_load};

    // Tracker chain: slot 1 takes decode (or a bubble), later slots shift down.
    for (genvar k = 1; k <= STAGES; k++) begin : g_trk
        if (k == 1) begin : g_head
            pipe_track_entry u_entry (
                .clk      (clk),
                .rst      (rst),
                .hold_i   (pipe_hold),
                .bubble_i (!issue),
                .d_i      (id_entry),
                .q_o      (trk_q[k])
            );
        end else begin : g_tail
            pipe_track_entry u_entry (
                .clk      (clk),
                .rst      (rst),
                .hold_i   (pipe_hold),
                .bubble_i (1'b0),
                .d_i      (trk_q[k-1]),
                .q_o      (trk_q[k])
            );
        end
    end

    // Pad the tracker view to the package's fixed depth; spare slots never match.
    for (genvar k = 0; k < MAX_STAGES; k++) begin : g_all
        if (k < STAGES) begin : g_used
            assign trk_all[k] = trk_q[k+1];
        end else begin : g_spare
            assign trk_all[k] = '0;
        end
    end

    assign match_a = youngest_match(trk_all, MAX_REG_AW'(id_src_a), id_use_a);
    assign match_b = youngest_match(trk_all, MAX_REG_AW'(id_src_b), id_use_b);

`ifdef PIPE_HAZARD_FORWARD_EN
    // Only a load that will not yet be in the last tracked stage cannot be bypassed.
    assign stall_a = match_a.hit && match_a.load && (match_a.idx < IDX_W'(STAGES - 1));
    assign stall_b = match_b.hit && match_b.load && (match_b.idx < IDX_W'(STAGES - 1));
`else
    // Without bypass paths, wait until the producer writes the bank in the last stage.
    assign stall_a = match_a.hit && (match_a.idx < IDX_W'(STAGES));
    assign stall_b = match_b.hit && (match_b.idx < IDX_W'(STAGES));
`endif

    assign hazard_stall = stall_a || stall_b;

    // Pipeline control: memory wait freezes all, then branch squash, then load-use stall.
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        pipe_hold = 1'b0;
        issue     = 1'b0;
        if (mem_wait) begin
            pipe_hold = 1'b1;
            stall_f   = 1'b1;
            stall_d   = 1'b1;
        end else if (ex_branch_taken) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (id_valid && hazard_stall) begin
            // Hold F/D and squash D/E so a bubble enters E behind the producer.
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            issue = id_valid;
        end
    end

`ifdef PIPE_HAZARD_FORWARD_EN
    logic [FW-1:0] fwd_a_d;
    logic [FW-1:0] fwd_b_d;
    logic [FW-1:0] fwd_a_q;
    logic [FW-1:0] fwd_b_q;

    // A producer now in stage j sits in stage j+1 once the consumer reaches E;
    // a producer already in the last stage is covered by the write-first bank.
    function automatic logic [FW-1:0] fwd_sel(input match_t m);
        if (m.hit && (m.idx < IDX_W'(STAGES))) begin
            return FW'(m.idx) + FW'(1);
        end
        return FW'(FWD_REG);
    endfunction

    // Next forwarding selects: captured on issue, cleared on a bubble, kept while frozen.
    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!pipe_hold) begin
            fwd_a_d = issue ? fwd_sel(match_a) : FW'(FWD_REG);
            fwd_b_d = issue ? fwd_sel(match_b) : FW'(FWD_REG);
        end
    end

    // Forwarding select registers, valid for the whole cycle the consumer is in E.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_q <= FW'(FWD_REG);
            fwd_b_q <= FW'(FWD_REG);
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_e = fwd_a_q;
    assign fwd_b_e = fwd_b_q;
`else
    assign fwd_a_e = FW'(FWD_REG);
    assign fwd_b_e = FW'(FWD_REG);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. With PIPE_HAZARD_FORWARD_EN defined it
// runs the forwarding scenarios at STAGES=3; otherwise the stall-only
// scenarios at STAGES=4. Inputs change 1 time unit after the rising edge and
// outputs are sampled 1 unit later, well away from the next edge.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_FORWARD_EN
    localparam int S = 3;
`else
    localparam int S = 4;
`endif
    localparam int AW  = 4;
    localparam int FWW = $clog2(S + 1);

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic [AW-1:0]   id_src_a;
    logic [AW-1:0]   id_src_b;
    logic            id_use_a;
    logic            id_use_b;
    logic [AW-1:0]   id_dst;
    logic            id_regw;
    logic            id_load;
    logic            ex_branch_taken;
    logic            mem_wait;
    logic            stall_f;
    logic            stall_d;
    logic            flush_d;
    logic            flush_e;
    logic            pipe_hold;
    logic            issue;
    logic [FWW-1:0]  fwd_a_e;
    logic [FWW-1:0]  fwd_b_e;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(
        .REG_AW (AW),
        .STAGES (S)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_src_a        (id_src_a),
        .id_src_b        (id_src_b),
        .id_use_a        (id_use_a),
        .id_use_b        (id_use_b),
        .id_dst          (id_dst),
        .id_regw         (id_regw),
        .id_load         (id_load),
        .ex_branch_taken (ex_branch_taken),
        .mem_wait        (mem_wait),
        .stall_f         (stall_f),
        .stall_d         (stall_d),
        .flush_d         (flush_d),
        .flush_e         (flush_e),
        .pipe_hold       (pipe_hold),
        .issue           (issue),
        .fwd_a_e         (fwd_a_e),
        .fwd_b_e         (fwd_b_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic v, input logic [AW-1:0] dst, input logic regw,
                       input logic load, input logic [AW-1:0] a, input logic ua,
                       input logic [AW-1:0] b, input logic ub);
        id_valid = v;
        id_dst   = dst;
        id_regw  = regw;
        id_load  = load;
        id_src_a = a;
        id_use_a = ua;
        id_src_b = b;
        id_use_b = ub;
    endtask

    initial begin
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        mem_wait = 1'b0;
        dec(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_stall_f", stall_f, 0);
        chk("rst_stall_d", stall_d, 0);
        chk("rst_flush_d", flush_d, 0);
        chk("rst_flush_e", flush_e, 0);
        chk("rst_hold", pipe_hold, 0);
        chk("rst_issue", issue, 0);
        chk("rst_fwd_a", fwd_a_e, 0);
        chk("rst_fwd_b", fwd_b_e, 0);
        tick();

`ifdef PIPE_HAZARD_FORWARD_EN
        // ADD r1 then ADD r2,r1,r3: forward from stage 2, no stall.
        dec(1, 1, 1, 0, 2, 1, 3, 1); #1;
        chk("add1_issue", issue, 1);
        chk("add1_nostall", stall_d, 0);
        tick();
        dec(1, 2, 1, 0, 1, 1, 3, 1); #1;
        chk("dep_nostall", stall_f, 0);
        chk("dep_issue", issue, 1);
        tick();
        chk("dep_fwd_a", fwd_a_e, 2);
        chk("dep_fwd_b", fwd_b_e, 0);

        // LOAD r4 then SUB r5,r4,r4: one stall cycle, then forward from W.
        dec(1, 4, 1, 1, 0, 0, 0, 0); #1;
        chk("ld_issue", issue, 1);
        tick();
        chk("ld_fwd_a", fwd_a_e, 0);
        dec(1, 5, 1, 0, 4, 1, 4, 1); #1;
        chk("lu_stall_f", stall_f, 1);
        chk("lu_stall_d", stall_d, 1);
        chk("lu_issue", issue, 0);
        tick();
        chk("lu_bubble_fwd_a", fwd_a_e, 0);
        #1;
        chk("lu_release_stall", stall_d, 0);
        chk("lu_release_issue", issue, 1);
        tick();
        chk("lu_fwd_a", fwd_a_e, 3);
        chk("lu_fwd_b", fwd_b_e, 3);

        // Two apart forwards from W; three apart reads the bank.
        dec(1, 6, 1, 0, 0, 0, 0, 0); tick();
        dec(1, 7, 0, 0, 0, 0, 0, 0); tick();
        dec(1, 8, 1, 0, 6, 1, 5, 1); #1;
        chk("dist_nostall", stall_d, 0);
        tick();
        chk("dist2_fwd_a", fwd_a_e, 3);
        chk("dist3_fwd_b", fwd_b_e, 0);

        // Branch beats a load-use stall; slot 1 is a bubble afterwards.
        dec(1, 9, 1, 1, 0, 0, 0, 0); tick();
        dec(1, 10, 1, 0, 9, 1, 0, 0);
        ex_branch_taken = 1'b1; #1;
        chk("br_flush_d", flush_d, 1);
        chk("br_flush_e", flush_e, 1);
        chk("br_stall_d", stall_d, 0);
        chk("br_stall_f", stall_f, 0);
        chk("br_issue", issue, 0);
        tick();
        ex_branch_taken = 1'b0;
        dec(1, 11, 1, 0, 10, 1, 9, 1); #1;
        chk("br_after_nostall", stall_d, 0);
        tick();
        chk("br_e1_bubble_fwd_a", fwd_a_e, 0);
        chk("br_ld_fwd_b", fwd_b_e, 3);

        // Four cycles of memory wait during a dependent decode.
        dec(1, 12, 1, 0, 11, 1, 9, 1);
        mem_wait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mw%0d_hold", i), pipe_hold, 1);
            chk($sformatf("mw%0d_stall", i), stall_d, 1);
            chk($sformatf("mw%0d_issue", i), issue, 0);
            chk($sformatf("mw%0d_fwd_b", i), fwd_b_e, 3);
            tick();
        end
        mem_wait = 1'b0; #1;
        chk("mw_rel_hold", pipe_hold, 0);
        chk("mw_rel_issue", issue, 1);
        tick();
        chk("mw_rel_fwd_a", fwd_a_e, 2);
        chk("mw_rel_fwd_b", fwd_b_e, 0);

        // Branch under memory wait waits for release.
        dec(0, 0, 0, 0, 0, 0, 0, 0);
        mem_wait = 1'b1;
        ex_branch_taken = 1'b1; #1;
        chk("mwbr_flush_d", flush_d, 0);
        chk("mwbr_flush_e", flush_e, 0);
        tick();
        chk("mwbr_fwd_held", fwd_a_e, 2);
        mem_wait = 1'b0; #1;
        chk("mwbr_rel_flush", flush_d, 1);

        // Reset mid-flush clears trackers and forwarding.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ex_branch_taken = 1'b0; #1;
        chk("rstfl_flush_d", flush_d, 0);
        chk("rstfl_fwd_a", fwd_a_e, 0);
        dec(1, 13, 1, 0, 12, 1, 0, 0); #1;
        chk("rstfl_issue", issue, 1);
        tick();
        chk("rstfl_trk_clear", fwd_a_e, 0);
`else
        // ADD r1 then a user of r1: three stall cycles, never forwarded.
        dec(1, 1, 1, 0, 2, 1, 3, 1); #1;
        chk("add1_issue", issue, 1);
        tick();
        dec(1, 2, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("nf_stall%0d_d", i), stall_d, 1);
            chk($sformatf("nf_stall%0d_f", i), stall_f, 1);
            chk($sformatf("nf_stall%0d_issue", i), issue, 0);
            chk($sformatf("nf_stall%0d_fwd", i), fwd_a_e, 0);
            tick();
        end
        #1;
        chk("nf_release_stall", stall_d, 0);
        chk("nf_release_issue", issue, 1);
        tick();
        chk("nf_fwd_a", fwd_a_e, 0);

        // Invalid decode never stalls; unused sources never match.
        dec(0, 3, 1, 0, 2, 1, 0, 0); #1;
        chk("inv_nostall", stall_d, 0);
        chk("inv_noissue", issue, 0);
        tick();
        dec(1, 3, 1, 0, 2, 0, 2, 0); #1;
        chk("nouse_nostall", stall_d, 0);
        chk("nouse_issue", issue, 1);
        tick();

        // Branch beats the hazard; load flag does not change the stall length.
        dec(1, 4, 1, 1, 0, 0, 0, 0); tick();
        dec(1, 5, 1, 0, 4, 1, 0, 0);
        ex_branch_taken = 1'b1; #1;
        chk("br_flush_d", flush_d, 1);
        chk("br_flush_e", flush_e, 1);
        chk("br_stall_d", stall_d, 0);
        chk("br_issue", issue, 0);
        tick();
        ex_branch_taken = 1'b0; #1;
        chk("br_after_stall", stall_d, 1);

        // Memory wait freezes the trackers: the load stays in stage 2.
        mem_wait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mw%0d_hold", i), pipe_hold, 1);
            chk($sformatf("mw%0d_flush", i), flush_e, 0);
            tick();
        end
        mem_wait = 1'b0; #1;
        chk("mw_rel_stall_e2", stall_d, 1);
        tick();
        chk("mw_rel_stall_e3", stall_d, 1);
        tick();
        chk("mw_rel_nostall_e4", stall_d, 0);
        chk("mw_rel_issue", issue, 1);
        tick();

        // Reset mid-stall: the stall is gone the next cycle.
        dec(1, 6, 1, 0, 5, 1, 0, 0); #1;
        chk("rsts_stall_before", stall_d, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("rsts_stall_after", stall_d, 0);
        chk("rsts_issue_after", issue, 1);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
